axi_scratch_slv: RTL and testbench

AXI4 subordinate (responder) backed by a small word-addressed register array, the terminating end for any AXI initiator, FIFO, or crossbar port in the fabric. Accepts one write and one read burst concurrently, at most one in flight per direction. Supports FIXED and INCR bursts and byte strobes. Used as scratchpad, boot-time mailbox, and protocol sink in subsystem benches.

---
 rtl/axi_pkg.sv | 75 +++++++
 rtl/axi_scratch_slv_pkg.sv | 13 +
 rtl/axi_scratch_slv_addr_gen.sv | 67 ++++++
 rtl/axi_scratch_slv.sv | 184 ++++++++++++++++++
 tb/tb_axi_scratch_slv.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// AXI4 response/burst encodings plus default channel and bundle types
// (32-bit address, 64-bit data, 4-bit ID) for the scratchpad subordinate.
package axi_pkg;

  typedef logic [1:0] resp_t;
  typedef logic [1:0] burst_t;

  localparam resp_t  RESP_OKAY   = 2'b00;
  localparam resp_t  RESP_EXOKAY = 2'b01;
  localparam resp_t  RESP_SLVERR = 2'b10;
  localparam resp_t  RESP_DECERR = 2'b11;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
  } def_aw_chan_t;

  typedef def_aw_chan_t def_ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
  } def_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    resp_t      resp;
    logic [0:0] user;
  } def_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    resp_t       resp;
    logic        last;
    logic [0:0]  user;
  } def_r_chan_t;

  typedef struct packed {
    def_aw_chan_t aw;
    logic         aw_valid;
    def_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    def_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } def_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    def_b_chan_t  b;
    logic         r_valid;
    def_r_chan_t  r;
  } def_resp_t;

endpackage

// File: rtl/axi_scratch_slv_pkg.sv
// Shared state encodings and helpers for axi_scratch_slv.
package axi_scratch_slv_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  localparam int unsigned BeatCntWidth = 8;

  function automatic logic is_oor(input logic [63:0] word_idx, input logic [63:0] num_words);
    return word_idx >= num_words;
  endfunction

endpackage

// File: rtl/axi_scratch_slv_addr_gen.sv
// Latched burst state for one direction: current address, beat count, word index.
// Out-of-range flag exists only when AXI_SCRATCH_SLV_DECERR_EN is defined.
module axi_scratch_slv_addr_gen
  import axi_scratch_slv_pkg::*;
#(
  parameter int unsigned NumWords  = 32'd16,
  parameter int unsigned AddrWidth = 32'd32,
  parameter int unsigned DataWidth = 32'd64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_i,
  input  logic                        adv_i,
  input  logic [AddrWidth-1:0]        addr_i,
  input  logic [BeatCntWidth-1:0]     len_i,
  input  logic [2:0]                  size_i,
  input  logic [1:0]                  burst_i,
`ifdef AXI_SCRATCH_SLV_DECERR_EN
  output logic                        oor_o,
`endif
  output logic [$clog2(NumWords)-1:0] idx_o,
  output logic                        last_o
);

  localparam int unsigned OffW = $clog2(DataWidth/8);
  localparam int unsigned IdxW = $clog2(NumWords);

  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [BeatCntWidth-1:0] len_q, cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;

  // WRAP and reserved encodings advance exactly like INCR
  always_comb begin
    addr_d = addr_q;
    if (burst_q != axi_pkg::BURST_FIXED) begin
      addr_d = addr_q + (AddrWidth'(1) << size_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      len_q   <= len_i;
      size_q  <= size_i;
      burst_q <= burst_i;
      cnt_q   <= '0;
    end else if (adv_i) begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign idx_o  = addr_q[OffW +: IdxW];
  assign last_o = (cnt_q == len_q);

`ifdef AXI_SCRATCH_SLV_DECERR_EN
  assign oor_o = is_oor(64'(addr_q[AddrWidth-1:OffW]), 64'(NumWords));
`endif

endmodule

// File: rtl/axi_scratch_slv.sv
// AXI4 subordinate backed by a word-addressed register array; one burst per direction.
// Define AXI_SCRATCH_SLV_DECERR_EN to drop out-of-range beats and answer DECERR.
module axi_scratch_slv
  import axi_scratch_slv_pkg::*;
#(
  parameter int unsigned NumWords   = 32'd16,
  parameter int unsigned AddrWidth  = 32'd32,
  parameter int unsigned DataWidth  = 32'd64,
  parameter int unsigned IdWidth    = 32'd4,
  parameter type         aw_chan_t  = axi_pkg::def_aw_chan_t,
  parameter type         w_chan_t   = axi_pkg::def_w_chan_t,
  parameter type         b_chan_t   = axi_pkg::def_b_chan_t,
  parameter type         ar_chan_t  = axi_pkg::def_ar_chan_t,
  parameter type         r_chan_t   = axi_pkg::def_r_chan_t,
  parameter type         axi_req_t  = axi_pkg::def_req_t,
  parameter type         axi_resp_t = axi_pkg::def_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o
);

  localparam int unsigned StrbWidth = DataWidth/8;
  localparam int unsigned IdxW      = $clog2(NumWords);

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q, ar_ready_q, r_valid_q;
  logic [IdWidth-1:0]    b_id_q, r_id_q;
  axi_pkg::resp_t        b_resp_q;
  logic                  w_err_q;
  logic [DataWidth-1:0]  mem_q [NumWords];

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IdxW-1:0]       w_idx, r_idx;
  logic                  w_last, r_last, w_drop, r_drop;

  assign aw_hs = slv_req_i.aw_valid & aw_ready_q;
  assign w_hs  = slv_req_i.w_valid  & w_ready_q;
  assign b_hs  = slv_req_i.b_ready  & b_valid_q;
  assign ar_hs = slv_req_i.ar_valid & ar_ready_q;
  assign r_hs  = slv_req_i.r_ready  & r_valid_q;

`ifdef AXI_SCRATCH_SLV_DECERR_EN
  logic w_oor, r_oor;
  assign w_drop = w_oor;
  assign r_drop = r_oor;
`else
  assign w_drop = 1'b0;
  assign r_drop = 1'b0;
`endif

  axi_scratch_slv_addr_gen #(
    .NumWords (NumWords),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) i_wgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (aw_hs),
    .adv_i  (w_hs),
    .addr_i (slv_req_i.aw.addr),
    .len_i  (slv_req_i.aw.len),
    .size_i (slv_req_i.aw.size),
    .burst_i(slv_req_i.aw.burst),
`ifdef AXI_SCRATCH_SLV_DECERR_EN
    .oor_o  (w_oor),
`endif
    .idx_o  (w_idx),
    .last_o (w_last)
  );

  axi_scratch_slv_addr_gen #(
    .NumWords (NumWords),
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) i_rgen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ar_hs),
    .adv_i  (r_hs),
    .addr_i (slv_req_i.ar.addr),
    .len_i  (slv_req_i.ar.len),
    .size_i (slv_req_i.ar.size),
    .burst_i(slv_req_i.ar.burst),
`ifdef AXI_SCRATCH_SLV_DECERR_EN
    .oor_o  (r_oor),
`endif
    .idx_o  (r_idx),
    .last_o (r_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= axi_pkg::RESP_OKAY;
      w_err_q    <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: if (aw_hs) begin
          b_id_q     <= slv_req_i.aw.id;
          w_err_q    <= 1'b0;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
          w_state_q  <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (w_drop) w_err_q <= 1'b1;
          // w.last is ignored; the beat counter alone closes the burst
          if (w_last) begin
            b_resp_q  <= (w_err_q | w_drop) ? axi_pkg::RESP_DECERR : axi_pkg::RESP_OKAY;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (b_hs) begin
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_state_q  <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_id_q     <= slv_req_i.ar.id;
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_state_q  <= R_DATA;
        end
        R_DATA: if (r_hs && r_last) begin
          r_valid_q  <= 1'b0;
          ar_ready_q <= 1'b1;
          r_state_q  <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (w_hs && !w_drop) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (slv_req_i.w.strb[b]) mem_q[w_idx][b*8 +: 8] <= slv_req_i.w.data[b*8 +: 8];
      end
    end
  end

  // R payload is forced to zero whenever no beat is being offered
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready_q;
    slv_resp_o.w_ready  = w_ready_q;
    slv_resp_o.b_valid  = b_valid_q;
    slv_resp_o.b.id     = b_id_q;
    slv_resp_o.b.resp   = b_resp_q;
    slv_resp_o.ar_ready = ar_ready_q;
    slv_resp_o.r_valid  = r_valid_q;
    if (r_valid_q) begin
      slv_resp_o.r.id   = r_id_q;
      slv_resp_o.r.data = r_drop ? '0 : mem_q[r_idx];
      slv_resp_o.r.resp = r_drop ? axi_pkg::RESP_DECERR : axi_pkg::RESP_OKAY;
      slv_resp_o.r.last = r_last;
    end
  end

endmodule

// File: tb/tb_axi_scratch_slv.sv
// Self-checking bench for axi_scratch_slv: vector table, directed corner cases,
// and randomized bursts checked against a behavioural memory model.
module tb_axi_scratch_slv;
  import axi_pkg::*;

  localparam int unsigned NW = 16;
`ifdef AXI_SCRATCH_SLV_DECERR_EN
  localparam bit DecErr = 1'b1;
`else
  localparam bit DecErr = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  def_req_t  req;
  def_resp_t resp;

  always #5 clk = ~clk;

  axi_scratch_slv #(
    .NumWords  (32'd16),
    .AddrWidth (32'd32),
    .DataWidth (32'd64),
    .IdWidth   (32'd4),
    .aw_chan_t (def_aw_chan_t),
    .w_chan_t  (def_w_chan_t),
    .b_chan_t  (def_b_chan_t),
    .ar_chan_t (def_ar_chan_t),
    .r_chan_t  (def_r_chan_t),
    .axi_req_t (def_req_t),
    .axi_resp_t(def_resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (req),
    .slv_resp_o(resp)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] model [NW];
  bit nopat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: handshake not seen within cycle bound", name);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input int size,
                                            input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return DecErr ? ((a / 8) < NW) : 1'b1;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 8) % NW);
  endfunction

  task automatic model_write(input logic [31:0] a, input int len, input int size, input logic [1:0] burst,
                             input logic [63:0] data[$], input logic [7:0] strb[$], output logic [1:0] r);
    r = RESP_OKAY;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] ba = beat_addr(a, i, size, burst);
      if (!in_range(ba)) r = RESP_DECERR;
      else for (int l = 0; l < 8; l++)
        if (strb[i][l]) model[widx(ba)][l*8 +: 8] = data[i][l*8 +: 8];
    end
  endtask

  task automatic model_read(input logic [31:0] a, input int len, input int size, input logic [1:0] burst,
                            output logic [63:0] d[$], output logic [1:0] r[$]);
    d = {};
    r = {};
    for (int i = 0; i <= len; i++) begin
      logic [31:0] ba = beat_addr(a, i, size, burst);
      d.push_back(in_range(ba) ? model[widx(ba)] : 64'h0);
      r.push_back(in_range(ba) ? RESP_OKAY : RESP_DECERR);
    end
  endtask

  // ---------------- bus drivers ----------------
  function automatic logic rdy(input int which);
    case (which)
      0:       return resp.aw_ready;
      1:       return resp.w_ready;
      2:       return resp.b_valid;
      3:       return resp.ar_ready;
      default: return resp.r_valid;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string name);
    int t = 0;
    while (!rdy(which) && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!rdy(which)) timeout(name);
  endtask

  task automatic axi_write(input logic [31:0] a, input int len, input int size, input logic [1:0] burst,
                           input logic [3:0] id, input logic [63:0] data[$], input logic [7:0] strb[$],
                           output logic [1:0] bresp, output logic [3:0] bid);
    req.aw = '0;
    req.aw.addr = a; req.aw.len = 8'(len); req.aw.size = 3'(size);
    req.aw.burst = burst; req.aw.id = id;
    req.aw_valid = 1'b1;
    @(negedge clk);
    wait_hi(0, "aw_ready");
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      req.w.data = data[i]; req.w.strb = strb[i]; req.w.last = (i == len);
      req.w_valid = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        check("w_ready_latency", resp.w_ready, 1'b1);
        check("aw_ready_busy", resp.aw_ready, 1'b0);
      end
      wait_hi(1, "w_ready");
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
    req.b_ready = 1'b1;
    @(negedge clk);
    check("b_latency", resp.b_valid, 1'b1);
    wait_hi(2, "b_valid");
    bresp = resp.b.resp;
    bid   = resp.b.id;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int len, input int size, input logic [1:0] burst,
                          input logic [3:0] id, input bit pat[$],
                          output logic [63:0] d[$], output logic [1:0] rs[$], output logic l[$],
                          output logic [3:0] ids[$]);
    bit done = 1'b0;
    bit stalled = 1'b0;
    logic [63:0] sd = '0;
    logic sl = 1'b0;
    d = {}; rs = {}; l = {}; ids = {};
    req.ar = '0;
    req.ar.addr = a; req.ar.len = 8'(len); req.ar.size = 3'(size);
    req.ar.burst = burst; req.ar.id = id;
    req.ar_valid = 1'b1;
    @(negedge clk);
    wait_hi(3, "ar_ready");
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      req.r_ready = (cyc < pat.size()) ? pat[cyc] : 1'b1;
      @(negedge clk);
      if (cyc == 0) begin
        check("r_latency", resp.r_valid, 1'b1);
        check("ar_ready_busy", resp.ar_ready, 1'b0);
      end
      if (stalled) begin
        check("r_hold_valid", resp.r_valid, 1'b1);
        check("r_hold_data", resp.r.data, sd);
        check("r_hold_last", resp.r.last, sl);
      end
      if (resp.r_valid && req.r_ready) begin
        d.push_back(resp.r.data); rs.push_back(resp.r.resp);
        l.push_back(resp.r.last); ids.push_back(resp.r.id);
        done = resp.r.last;
        stalled = 1'b0;
      end else begin
        stalled = resp.r_valid;
        sd = resp.r.data;
        sl = resp.r.last;
      end
      @(posedge clk); #1;
    end
    req.r_ready = 1'b0;
    if (!done) timeout("r_last");
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input int len, input int size,
                            input logic [1:0] burst, input logic [3:0] id, input bit pat[$]);
    logic [63:0] ed[$], ad[$];
    logic [1:0]  er[$], ars[$];
    logic        al[$];
    logic [3:0]  ai[$];
    model_read(a, len, size, burst, ed, er);
    axi_read(a, len, size, burst, id, pat, ad, ars, al, ai);
    check({name, "_beats"}, 64'(ad.size()), 64'(len + 1));
    for (int i = 0; i <= len && i < ad.size(); i++) begin
      check({name, "_data"}, ad[i], ed[i]);
      check({name, "_resp"}, ars[i], er[i]);
      check({name, "_last"}, al[i], (i == len));
      check({name, "_id"}, ai[i], id);
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input int len, input int size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input logic [63:0] data[$], input logic [7:0] strb[$]);
    logic [1:0] er, br;
    logic [3:0] bi;
    model_write(a, len, size, burst, data, strb, er);
    axi_write(a, len, size, burst, id, data, strb, br, bi);
    check({name, "_bresp"}, br, er);
    check({name, "_bid"}, bi, id);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [3:0]  id;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dq[$];
    logic [7:0]  sq[$];
    logic [1:0]  br, dummy;
    logic [3:0]  bi;
    logic [63:0] ad[$];
    logic [1:0]  ars[$];
    logic        al[$];
    logic [3:0]  ai[$];
    bit bp[$];

    tbl[0] = '{32'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'd5, 64'hDEAD_BEEF_0123_4567};
    tbl[1] = '{32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[2] = '{32'h10, 64'h0,                   8'h0F, 4'd2, 64'hFFFF_FFFF_0000_0000};
    tbl[3] = '{32'h18, 64'hA,                   8'hFF, 4'd3, 64'hA};
    tbl[4] = '{32'h20, 64'h1122_3344_5566_7788, 8'h81, 4'd4, 64'h1100_0000_0000_0088};
    tbl[5] = '{32'h7B, 64'h0123,                8'h03, 4'd6, 64'h0123};

    req = '0;
    rst = 1'b1;
    for (int i = 0; i < NW; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", resp.aw_ready, 1'b1);
    check("rst_ar_ready", resp.ar_ready, 1'b1);
    check("rst_w_ready", resp.w_ready, 1'b0);
    check("rst_b_valid", resp.b_valid, 1'b0);
    check("rst_r_valid", resp.r_valid, 1'b0);
    check("rst_b_payload", {resp.b.id, resp.b.resp}, '0);
    check("rst_r_payload", {resp.r.id, resp.r.data, resp.r.resp, resp.r.last}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      dq = {tbl[v].wdata};
      sq = {tbl[v].strb};
      model_write(tbl[v].addr, 0, 3, BURST_INCR, dq, sq, dummy);
      axi_write(tbl[v].addr, 0, 3, BURST_INCR, tbl[v].id, dq, sq, br, bi);
      check("tbl_bresp", br, RESP_OKAY);
      check("tbl_bid", bi, tbl[v].id);
      axi_read(tbl[v].addr, 0, 3, BURST_INCR, tbl[v].id ^ 4'hF, nopat, ad, ars, al, ai);
      check("tbl_rbeats", 64'(ad.size()), 64'd1);
      if (ad.size() > 0) begin
        check("tbl_rdata", ad[0], tbl[v].exp_rdata);
        check("tbl_rlast", al[0], 1'b1);
        check("tbl_rid", ai[0], tbl[v].id ^ 4'hF);
      end
    end

    // INCR burst into words 4..7, FIXED burst hammering word 1
    dq = {64'h4444_0000_0000_0004, 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006, 64'h7777_0000_0000_0007};
    sq = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write("incr_wr", 32'h20, 3, 3, BURST_INCR, 4'd2, dq, sq);
    check_read("incr_rd", 32'h20, 3, 3, BURST_INCR, 4'd3, nopat);
    dq = {64'd1, 64'd2, 64'd3, 64'd4};
    do_write("fixed_wr", 32'h08, 3, 3, BURST_FIXED, 4'd4, dq, sq);
    check_read("fixed_rd", 32'h08, 3, 3, BURST_FIXED, 4'd5, nopat);
    check("fixed_word1", model[1], 64'd4);

    bp = {1'b1, 1'b0, 1'b0, 1'b1};
    check_read("bp_rd", 32'h20, 3, 3, BURST_INCR, 4'd6, bp);

    // AW and AR to word 3 together: read sees the old value, write lands at the same edge
    req.aw = '0; req.aw.addr = 32'h18; req.aw.size = 3'd3; req.aw.burst = BURST_INCR; req.aw.id = 4'd7;
    req.ar = '0; req.ar.addr = 32'h18; req.ar.size = 3'd3; req.ar.burst = BURST_INCR; req.ar.id = 4'd9;
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    @(negedge clk);
    check("conc_aw_ready", resp.aw_ready, 1'b1);
    check("conc_ar_ready", resp.ar_ready, 1'b1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    req.w.data = 64'hB; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
    req.r_ready = 1'b1;
    @(negedge clk);
    check("conc_w_ready", resp.w_ready, 1'b1);
    check("conc_r_valid", resp.r_valid, 1'b1);
    check("conc_r_data", resp.r.data, 64'hA);
    @(posedge clk); #1;
    req.w_valid = 1'b0;
    req.r_ready = 1'b0;
    req.b_ready = 1'b1;
    @(negedge clk);
    check("conc_b_valid", resp.b_valid, 1'b1);
    check("conc_b_id", resp.b.id, 4'd7);
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    model[3] = 64'hB;
    check_read("conc_after", 32'h18, 0, 3, BURST_INCR, 4'd1, nopat);

    // INCR len 1 from word 15 crosses the end of the array
    dq = {64'hAAAA_0000_0000_000F, 64'hBBBB_0000_0000_0010};
    sq = {8'hFF, 8'hFF};
    axi_write(32'h78, 1, 3, BURST_INCR, 4'd8, dq, sq, br, bi);
    check("oor_bresp", br, DecErr ? RESP_DECERR : RESP_OKAY);
    model_write(32'h78, 1, 3, BURST_INCR, dq, sq, dummy);
    check_read("oor_word0", 32'h00, 0, 3, BURST_INCR, 4'd2, nopat);
    check_read("oor_rd", 32'h78, 1, 3, BURST_INCR, 4'd3, nopat);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] a;
      int len, size;
      logic [1:0] burst;
      logic [3:0] id;
      a = 32'($urandom_range(0, 159));
      len = $urandom_range(0, 5);
      size = $urandom_range(0, 3);
      burst = 2'($urandom_range(0, 3));
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        dq = {};
        sq = {};
        for (int i = 0; i <= len; i++) begin
          dq.push_back({$urandom, $urandom});
          sq.push_back(8'($urandom));
        end
        do_write("rnd_wr", a, len, size, burst, id, dq, sq);
      end else begin
        check_read("rnd_rd", a, len, size, burst, id, nopat);
      end
    end

    // reset during beat 1 of a 4-beat read
    req.ar = '0; req.ar.addr = 32'h20; req.ar.len = 8'd3; req.ar.size = 3'd3;
    req.ar.burst = BURST_INCR; req.ar.id = 4'd5;
    req.ar_valid = 1'b1;
    @(negedge clk);
    wait_hi(3, "rst_ar");
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    req.r_ready = 1'b1;
    @(negedge clk);
    check("rstmid_beat0_valid", resp.r_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req.r_ready = 1'b0;
    @(negedge clk);
    check("rstmid_r_valid", resp.r_valid, 1'b0);
    check("rstmid_ar_ready", resp.ar_ready, 1'b1);
    check("rstmid_aw_ready", resp.aw_ready, 1'b1);
    for (int i = 0; i < NW; i++) model[i] = '0;
    @(posedge clk); #1;
    check_read("rstmid_cleared", 32'h20, 1, 3, BURST_INCR, 4'd6, nopat);
    check_read("rstmid_cleared1", 32'h08, 0, 3, BURST_INCR, 4'd7, nopat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
